// File: rtl/cpu_pkg.sv
// Shared constants for the MIPS core: ALU control codes produced by the
// decode-stage ALU decoder and the EX forwarding select encodings.
package cpu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Overflow is only meaningful for add/sub.
    function automatic logic is_arith(input logic [2:0] ctrl);
        return (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: add/sub/and/or/slt with zero and signed-overflow flags.
// Unknown control codes produce a zero result and no overflow.
module alu_core
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             a_neg;
    logic             b_neg;

    assign sum   = a + b;
    assign diff  = a - b;
    assign a_neg = a[WIDTH-1];
    assign b_neg = b[WIDTH-1];

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (ctrl)
            ALU_ADD: begin
                result = sum;
                ovf    = (a_neg == b_neg) && (sum[WIDTH-1] != a_neg);
            end
            ALU_SUB: begin
                result = diff;
                ovf    = (a_neg != b_neg) && (diff[WIDTH-1] != a_neg);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
        if (!is_arith(ctrl)) begin
            ovf = 1'b0;
        end
    end

    assign zero = (result == '0);

endmodule

// File: rtl/id_ex_alu_stage.sv
// Execute stage: ID/EX register, operand forwarding muxes, ALU and EX/MEM
// register. stall_e holds both registers and overrides flush_e.
module id_ex_alu_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_d,
    input  logic [2:0]            alu_ctrl_d,
    input  logic [WIDTH-1:0]      rs_val_d,
    input  logic [WIDTH-1:0]      rt_val_d,
    input  logic [WIDTH-1:0]      imm_d,
    input  logic                  alu_src_d,
    input  logic [REG_ADDR_W-1:0] dst_d,
    input  logic                  reg_write_d,
    input  logic                  stall_e,
    input  logic                  flush_e,
    input  logic [1:0]            fwd_a_e,
    input  logic [1:0]            fwd_b_e,
    input  logic [WIDTH-1:0]      wb_result_w,
    output logic [REG_ADDR_W-1:0] dst_e,
    output logic                  reg_write_e,
    output logic                  valid_m,
    output logic [WIDTH-1:0]      alu_result_m,
    output logic [WIDTH-1:0]      write_data_m,
    output logic                  zero_m,
    output logic                  ovf_m,
    output logic [REG_ADDR_W-1:0] dst_m,
    output logic                  reg_write_m
);

    logic             valid_e;
    logic [2:0]       alu_ctrl_e;
    logic [WIDTH-1:0] rs_val_e;
    logic [WIDTH-1:0] rt_val_e;
    logic [WIDTH-1:0] imm_e;
    logic             alu_src_e;

    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] rt_fwd;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_e     <= 1'b0;
            alu_ctrl_e  <= '0;
            rs_val_e    <= '0;
            rt_val_e    <= '0;
            imm_e       <= '0;
            alu_src_e   <= 1'b0;
            dst_e       <= '0;
            reg_write_e <= 1'b0;
        end else if (stall_e) begin
            valid_e <= valid_e;
        end else if (flush_e) begin
            valid_e     <= 1'b0;
            alu_ctrl_e  <= '0;
            rs_val_e    <= '0;
            rt_val_e    <= '0;
            imm_e       <= '0;
            alu_src_e   <= 1'b0;
            dst_e       <= '0;
            reg_write_e <= 1'b0;
        end else begin
            valid_e     <= valid_d;
            alu_ctrl_e  <= alu_ctrl_d;
            rs_val_e    <= rs_val_d;
            rt_val_e    <= rt_val_d;
            imm_e       <= imm_d;
            alu_src_e   <= alu_src_d;
            dst_e       <= dst_d;
            reg_write_e <= reg_write_d & valid_d;
        end
    end

    // Code 11 is unused and falls back to the latched register value.
    always_comb begin
        case (fwd_a_e)
            FWD_MEM: src_a = alu_result_m;
            FWD_WB:  src_a = wb_result_w;
            default: src_a = rs_val_e;
        endcase
        case (fwd_b_e)
            FWD_MEM: rt_fwd = alu_result_m;
            FWD_WB:  rt_fwd = wb_result_w;
            default: rt_fwd = rt_val_e;
        endcase
        src_b = alu_src_e ? imm_e : rt_fwd;
    end

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .a      (src_a),
        .b      (src_b),
        .ctrl   (alu_ctrl_e),
        .result (alu_result),
        .zero   (alu_zero),
        .ovf    (alu_ovf)
    );

    // A bubble is gated to all-zero so forwarded values cannot leak into it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_m      <= 1'b0;
            alu_result_m <= '0;
            write_data_m <= '0;
            zero_m       <= 1'b0;
            ovf_m        <= 1'b0;
            dst_m        <= '0;
            reg_write_m  <= 1'b0;
        end else if (!stall_e) begin
            valid_m      <= valid_e;
            alu_result_m <= valid_e ? alu_result : '0;
            write_data_m <= valid_e ? rt_fwd : '0;
            zero_m       <= valid_e & alu_zero;
            ovf_m        <= valid_e & alu_ovf;
            dst_m        <= valid_e ? dst_e : '0;
            reg_write_m  <= valid_e & reg_write_e;
        end
    end

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Bench for id_ex_alu_stage: directed test-plan scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_id_ex_alu_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid_d, alu_src_d, reg_write_d, stall_e, flush_e;
    logic [2:0]  alu_ctrl_d;
    logic [31:0] rs_val_d, rt_val_d, imm_d, wb_result_w;
    logic [4:0]  dst_d;
    logic [1:0]  fwd_a_e, fwd_b_e;
    logic [4:0]  dst_e, dst_m;
    logic        reg_write_e, valid_m, zero_m, ovf_m, reg_write_m;
    logic [31:0] alu_result_m, write_data_m;

    int tests = 0;
    int fails = 0;
    logic chk_on = 1'b0;

    typedef struct packed {
        logic        valid;
        logic [2:0]  ctrl;
        logic [31:0] rs, rt, imm;
        logic        src;
        logic [4:0]  dst;
        logic        rw;
    } ex_slot_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] res, wd;
        logic        zero, ovf;
        logic [4:0]  dst;
        logic        rw;
    } mem_slot_t;

    ex_slot_t  mi;
    mem_slot_t mm;

    id_ex_alu_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .alu_ctrl_d(alu_ctrl_d),
        .rs_val_d(rs_val_d), .rt_val_d(rt_val_d), .imm_d(imm_d),
        .alu_src_d(alu_src_d), .dst_d(dst_d), .reg_write_d(reg_write_d),
        .stall_e(stall_e), .flush_e(flush_e), .fwd_a_e(fwd_a_e),
        .fwd_b_e(fwd_b_e), .wb_result_w(wb_result_w), .dst_e(dst_e),
        .reg_write_e(reg_write_e), .valid_m(valid_m),
        .alu_result_m(alu_result_m), .write_data_m(write_data_m),
        .zero_m(zero_m), .ovf_m(ovf_m), .dst_m(dst_m),
        .reg_write_m(reg_write_m)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU in plain signed arithmetic on 64-bit integers.
    task automatic ref_alu(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic ovf);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 32'd0;
        ovf = 1'b0;
        if (ctrl == 3'b010 || ctrl == 3'b110) begin
            s = (ctrl == 3'b010) ? sa + sb : sa - sb;
            res = s[31:0];
            ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (ctrl == 3'b000) res = a & b;
        else if (ctrl == 3'b001) res = a | b;
        else if (ctrl == 3'b111) res = (sa < sb) ? 32'd1 : 32'd0;
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v,
                                         input logic [31:0] mem_v, input logic [31:0] wb_v);
        if (sel == 2'b01) return mem_v;
        if (sel == 2'b10) return wb_v;
        return reg_v;
    endfunction

    // One clock edge: advance the model using the inputs present at the edge.
    task automatic step();
        ex_slot_t    ni;
        mem_slot_t   nm;
        logic [31:0] a, rtf, b, res;
        logic        ovf;
        @(posedge clk);
        if (!rst_n) begin
            mi = '0;
            mm = '0;
        end else if (!stall_e) begin
            nm = '0;
            if (mi.valid) begin
                a   = pick(fwd_a_e, mi.rs, mm.res, wb_result_w);
                rtf = pick(fwd_b_e, mi.rt, mm.res, wb_result_w);
                b   = mi.src ? mi.imm : rtf;
                ref_alu(mi.ctrl, a, b, res, ovf);
                nm = '{1'b1, res, rtf, (res == 32'd0), ovf, mi.dst, mi.rw};
            end
            if (flush_e) ni = '0;
            else ni = '{valid_d, alu_ctrl_d, rs_val_d, rt_val_d, imm_d, alu_src_d, dst_d,
                        reg_write_d & valid_d};
            mi = ni;
            mm = nm;
        end
        #2;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("dst_e", {27'd0, dst_e}, {27'd0, mi.dst});
            chk("reg_write_e", {31'd0, reg_write_e}, {31'd0, mi.rw});
            chk("valid_m", {31'd0, valid_m}, {31'd0, mm.valid});
            chk("alu_result_m", alu_result_m, mm.res);
            chk("write_data_m", write_data_m, mm.wd);
            chk("zero_m", {31'd0, zero_m}, {31'd0, mm.zero});
            chk("ovf_m", {31'd0, ovf_m}, {31'd0, mm.ovf});
            chk("dst_m", {27'd0, dst_m}, {27'd0, mm.dst});
            chk("reg_write_m", {31'd0, reg_write_m}, {31'd0, mm.rw});
        end
    end

    task automatic set_idle();
        valid_d = 0; alu_ctrl_d = 0; rs_val_d = 0; rt_val_d = 0; imm_d = 0;
        alu_src_d = 0; dst_d = 0; reg_write_d = 0; stall_e = 0; flush_e = 0;
        fwd_a_e = 0; fwd_b_e = 0; wb_result_w = 0;
    endtask

    task automatic set_instr(input logic [2:0] ctrl, input logic [31:0] rs, input logic [31:0] rt,
                             input logic [31:0] imm, input logic src, input logic [4:0] dst);
        set_idle();
        valid_d = 1; reg_write_d = 1; alu_ctrl_d = ctrl; rs_val_d = rs; rt_val_d = rt;
        imm_d = imm; alu_src_d = src; dst_d = dst;
    endtask

    // Issue one instruction followed by an idle slot; result is then on _m.
    task automatic run1(input logic [2:0] ctrl, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] imm, input logic src, input logic [4:0] dst);
        set_instr(ctrl, rs, rt, imm, src, dst);
        step();
        set_idle();
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dst_e"}, {27'd0, dst_e}, 32'd0);
        chk({tag, "_reg_write_e"}, {31'd0, reg_write_e}, 32'd0);
        chk({tag, "_valid_m"}, {31'd0, valid_m}, 32'd0);
        chk({tag, "_result_m"}, alu_result_m, 32'd0);
        chk({tag, "_write_data_m"}, write_data_m, 32'd0);
        chk({tag, "_zero_m"}, {31'd0, zero_m}, 32'd0);
        chk({tag, "_ovf_m"}, {31'd0, ovf_m}, 32'd0);
        chk({tag, "_dst_m"}, {27'd0, dst_m}, 32'd0);
        chk({tag, "_reg_write_m"}, {31'd0, reg_write_m}, 32'd0);
    endtask

    initial begin
        mi = '0;
        mm = '0;
        set_idle();
        valid_d = 1; reg_write_d = 1; alu_ctrl_d = 3'b010; rs_val_d = 32'hDEAD_BEEF;
        rt_val_d = 32'h1234_5678; dst_d = 5'd17; fwd_a_e = 2'b01; wb_result_w = 32'hFFFF_FFFF;
        #1 rst_n = 1'b0;
        chk_on = 1'b1;
        step();
        step();
        chk_all_zero("reset");
        #1 rst_n = 1'b1;

        run1(ALU_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3);
        chk("add_result", alu_result_m, 32'd12);
        chk("add_dst", {27'd0, dst_m}, 32'd3);
        chk("add_rw", {31'd0, reg_write_m}, 32'd1);
        chk("add_zero", {31'd0, zero_m}, 32'd0);

        run1(ALU_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd4);
        chk("sub_ovf_result", alu_result_m, 32'h8000_0000);
        chk("sub_ovf_flag", {31'd0, ovf_m}, 32'd1);
        run1(ALU_SUB, 32'd9, 32'd9, 32'd0, 1'b0, 5'd4);
        chk("sub_zero_result", alu_result_m, 32'd0);
        chk("sub_zero_flag", {31'd0, zero_m}, 32'd1);
        chk("sub_zero_ovf", {31'd0, ovf_m}, 32'd0);

        run1(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd5);
        chk("slt_neg_pos", alu_result_m, 32'd1);
        run1(ALU_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd5);
        chk("slt_pos_neg", alu_result_m, 32'd0);
        run1(3'b100, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd5);
        chk("bad_ctrl_result", alu_result_m, 32'd0);
        chk("bad_ctrl_ovf", {31'd0, ovf_m}, 32'd0);

        set_instr(ALU_ADD, 32'd2, 32'd0, 32'd3, 1'b1, 5'd8);
        step();
        set_instr(ALU_ADD, 32'd99, 32'd0, 32'd10, 1'b1, 5'd9);
        step();
        set_idle();
        fwd_a_e = FWD_MEM;
        step();
        chk("fwd_mem_result", alu_result_m, 32'd15);
        set_instr(ALU_ADD, 32'd1, 32'h55, 32'd0, 1'b0, 5'd10);
        step();
        set_idle();
        fwd_b_e = FWD_WB;
        wb_result_w = 32'hA;
        step();
        chk("fwd_wb_result", alu_result_m, 32'hB);
        chk("fwd_wb_store", write_data_m, 32'hA);

        set_instr(ALU_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 5'd4);
        step();
        set_instr(ALU_OR, 32'hF, 32'hF0, 32'd0, 1'b0, 5'd5);
        flush_e = 1'b1;
        step();
        chk("pre_flush_result", alu_result_m, 32'd3);
        set_instr(ALU_AND, 32'hF0, 32'h3C, 32'd0, 1'b0, 5'd6);
        step();
        chk("flush_valid", {31'd0, valid_m}, 32'd0);
        chk("flush_rw", {31'd0, reg_write_m}, 32'd0);
        chk("flush_result", alu_result_m, 32'd0);
        set_idle();
        step();
        chk("post_flush_result", alu_result_m, 32'h30);
        chk("post_flush_dst", {27'd0, dst_m}, 32'd6);

        set_instr(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd1);
        step();
        set_instr(ALU_ADD, 32'd2, 32'd2, 32'd0, 1'b0, 5'd2);
        step();
        set_instr(ALU_ADD, 32'd5, 32'd5, 32'd0, 1'b0, 5'd7);
        stall_e = 1'b1;
        flush_e = 1'b1;
        step();
        step();
        chk("stall_result", alu_result_m, 32'd2);
        chk("stall_dst_m", {27'd0, dst_m}, 32'd1);
        chk("stall_dst_e", {27'd0, dst_e}, 32'd2);
        stall_e = 1'b0;
        flush_e = 1'b0;
        step();
        chk("resume_b_result", alu_result_m, 32'd4);
        chk("resume_dst_e", {27'd0, dst_e}, 32'd7);
        set_idle();
        step();
        chk("resume_c_result", alu_result_m, 32'd10);

        for (int i = 0; i < 400; i++) begin
            logic [2:0] codes [0:5];
            codes = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, 3'($urandom_range(0, 7))};
            valid_d     = ($urandom_range(0, 9) != 0);
            alu_ctrl_d  = codes[$urandom_range(0, 5)];
            rs_val_d    = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 - 32'($urandom_range(0, 2)) : $urandom;
            rt_val_d    = ($urandom_range(0, 3) == 0) ? rs_val_d : $urandom;
            imm_d       = $urandom;
            alu_src_d   = 1'($urandom_range(0, 1));
            dst_d       = 5'($urandom_range(0, 31));
            reg_write_d = ($urandom_range(0, 4) != 0);
            stall_e     = ($urandom_range(0, 7) == 0);
            flush_e     = ($urandom_range(0, 7) == 0);
            fwd_a_e     = 2'($urandom_range(0, 3));
            fwd_b_e     = 2'($urandom_range(0, 3));
            wb_result_w = $urandom;
            if (i == 200) begin
                #1 rst_n = 1'b0;
                mi = '0;
                mm = '0;
                #1 chk_all_zero("async_reset");
                step();
                #1 rst_n = 1'b1;
            end
            step();
        end

        set_idle();
        step();
        step();
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/id_ex_alu_stage.md
Name: id_ex_alu_stage

Overview:
- Execute stage of the 5-stage pipelined MIPS core.
- Contains the ID/EX pipeline register, the EX forwarding muxes, the ALU, and the EX/MEM pipeline register.
- Consumes the 3-bit ALU control word produced by the decode-stage ALU decoder, plus the decoded operands.
- Delivers a registered result, store data and flags to the memory stage.

Parameters:
- WIDTH, 32, datapath width.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  in  1  single clock; all registers update on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_d  in  1  decode stage holds a real instruction.
- alu_ctrl_d  in  3  ALU control: 010 add, 110 sub, 000 and, 001 or, 111 slt; any other code produces result 0.
- rs_val_d  in  WIDTH  register-file rs value.
- rt_val_d  in  WIDTH  register-file rt value.
- imm_d  in  WIDTH  immediate, already extended.
- alu_src_d  in  1  operand B source: 1 = imm, 0 = rt.
- dst_d  in  REG_ADDR_W  destination register index.
- reg_write_d  in  1  instruction writes the register file.
- stall_e  in  1  hold both pipeline registers.
- flush_e  in  1  replace the ID/EX contents with a bubble.
- fwd_a_e  in  2  operand A forwarding select: 00 latched rs, 01 alu_result_m, 10 wb_result_w, 11 latched rs.
- fwd_b_e  in  2  same encoding as fwd_a_e, applied to rt.
- wb_result_w  in  WIDTH  writeback-stage value for forwarding.
- dst_e  out  REG_ADDR_W  ID/EX destination index, for the hazard unit.
- reg_write_e  out  1  ID/EX reg_write, for the hazard unit.
- valid_m  out  1  EX/MEM holds a real instruction.
- alu_result_m  out  WIDTH  registered ALU result.
- write_data_m  out  WIDTH  registered forwarded rt, used as store data.
- zero_m  out  1  registered (result == 0).
- ovf_m  out  1  registered signed overflow; defined for add/sub only, 0 otherwise; informational, no trap.
- dst_m  out  REG_ADDR_W  registered destination index.
- reg_write_m  out  1  registered reg_write, forced 0 when not valid.

Behaviour:
- Reset:
  - rst_n low asynchronously clears every ID/EX and EX/MEM field to 0.
  - All outputs read 0 while reset is asserted and after release until the first load.
- Latency: an instruction presented on the _d inputs at edge N appears on the _m outputs after edge N+1 (2 edges), absent stall.
- ID/EX register, priority stall_e > flush_e > load:
  - stall_e=1: hold.
  - flush_e=1 and stall_e=0: load a bubble (valid=0, reg_write=0, all other fields 0).
  - Otherwise: load the _d inputs; reg_write is captured as reg_write_d & valid_d.
- EX datapath (combinational from ID/EX):
  - a = mux(fwd_a_e); rtf = mux(fwd_b_e); b = alu_src ? imm : rtf.
  - add: a+b modulo 2^WIDTH. sub: a-b.
  - and/or: bitwise. slt: signed a<b gives 1, else 0, zero-extended.
  - ovf for add: a,b same sign and result sign differs. For sub: a,b signs differ and result sign differs from a.
  - Forwarding from alu_result_m uses the current EX/MEM contents, even when that entry is a bubble; the hazard unit guarantees correct selects.
- EX/MEM register:
  - stall_e=1: hold.
  - Otherwise: capture result, rtf into write_data_m, zero, ovf, dst, valid, and reg_write & valid.
  - An ID/EX bubble propagates as valid_m=0, reg_write_m=0, and all data fields 0.
- Simultaneous stall_e and flush_e: stall wins, and the flush is lost. The hazard unit must reassert flush_e after the stall.
- Reset mid-operation: in-flight instructions are discarded; no partial state survives.
- Unused fwd code 11 behaves exactly as 00.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU control constants ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111 (the same constants the decoder will use).
  - Forwarding select constants FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
- One sub-module is natural: alu_core, purely combinational (a, b, ctrl -> result, zero, ovf), instantiated once. Both pipeline registers and the forwarding muxes stay in the top level.

Test Plan:
- Reset with garbage on inputs -> all outputs 0; release, feed add rs=5, rt=7, alu_src=0, dst=3 -> two edges later alu_result_m=12, dst_m=3, reg_write_m=1, zero_m=0.
- sub 0x7FFFFFFF - 0xFFFFFFFF -> alu_result_m=0x80000000, ovf_m=1; sub 9-9 -> 0, zero_m=1, ovf_m=0.
- slt -1 vs 1 -> result 1; slt 1 vs -1 -> 0; alu_ctrl 100 -> result 0, ovf_m=0.
- Back-to-back add rs=2, imm=3 (alu_src=1), then an instruction with fwd_a_e=01 and imm=10 -> second result 15; same with fwd_b_e=10, wb_result_w=0xA, alu_src=0, rs=1 -> result 0xB and write_data_m=0xA.
- flush_e for one cycle during a valid instruction -> matching _m slot has valid_m=0, reg_write_m=0, result 0; neighbouring instructions are unaffected.
- stall_e and flush_e high together for 2 cycles -> all _m and _e outputs hold unchanged; dropping both resumes with no lost or duplicated instruction; asserting rst_n low mid-stream clears outputs immediately, without waiting for a clock edge.
